// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: memory func encoding, default widths, lock owner encoding.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  localparam logic [1:0] MEM_FUNC_RD = 2'h0;
  localparam logic [1:0] MEM_FUNC_WR = 2'h1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } lock_owner_e;

  function automatic logic func_legal(input logic [1:0] func);
    return (func == MEM_FUNC_RD) || (func == MEM_FUNC_WR);
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter with a bounded lock that lets one port keep the bus for multi-beat transfers.
//
// owner_q  | meaning
// OWN_NONE | no lock held, plain round-robin on rr_q
// OWN_P0   | port 0 holds the lock, cnt_q grants taken so far
// OWN_P1   | port 1 holds the lock, cnt_q grants taken so far
module dmem_rr_arb
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic lock0,
  input  logic lock1,
  output logic grant0,
  output logic grant1
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

  lock_owner_e owner_q, owner_d, win_owner;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic        rr_q, rr_d;
  logic        lock_act, win_lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      cnt_q   <= 4'd0;
      rr_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    owner_d  = OWN_NONE;
    cnt_d    = 4'd0;
    rr_d     = rr_q;
    lock_act = (((owner_q == OWN_P0) && valid0) || ((owner_q == OWN_P1) && valid1))
               && (cnt_q < MAX_CNT);

    if (lock_act) begin
      grant0 = (owner_q == OWN_P0);
      grant1 = (owner_q == OWN_P1);
    end else if (valid0 && valid1) begin
      grant0 = !rr_q;
      grant1 = rr_q;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end

    win_owner = grant1 ? OWN_P1 : OWN_P0;
    win_lock  = grant1 ? lock1 : lock0;
    cnt_inc   = ((owner_q == win_owner) ? cnt_q : 4'd0) + 4'd1;

    // Reaching MAX_LOCK drops the lock right away so the other port wins the next tie.
    if (grant0 || grant1) begin
      rr_d = grant0;
      if (win_lock && (cnt_inc < MAX_CNT)) begin
        owner_d = win_owner;
        cnt_d   = cnt_inc;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the load/store unit (port 0) and the host loader (port 1);
// drives the memory from the winner and registers a one-cycle response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic [ADDR_W-1:0] io_req0_addr,
  input  logic [DATA_W-1:0] io_req0_wdata,
  input  logic [1:0]        io_req0_func,
  input  logic              io_req0_lock,
  output logic              io_resp0_valid,
  output logic [DATA_W-1:0] io_resp0_data,
  output logic              io_resp0_err,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic [ADDR_W-1:0] io_req1_addr,
  input  logic [DATA_W-1:0] io_req1_wdata,
  input  logic [1:0]        io_req1_func,
  input  logic              io_req1_lock,
  output logic              io_resp1_valid,
  output logic [DATA_W-1:0] io_resp1_data,
  output logic              io_resp1_err,
  output logic [ADDR_W-1:0] io_mem_addr,
  output logic [DATA_W-1:0] io_mem_wr_data,
  output logic [1:0]        io_mem_func,
  output logic              io_mem_en,
  input  logic [DATA_W-1:0] io_mem_rd_data
);

  logic       grant0, grant1;
  logic [1:0] win_func;

  dmem_rr_arb #(.MAX_LOCK(MAX_LOCK)) u_rr_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (io_req0_valid),
    .valid1 (io_req1_valid),
    .lock0  (io_req0_lock),
    .lock1  (io_req1_lock),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign io_req0_ready = grant0;
  assign io_req1_ready = grant1;
  assign win_func      = grant1 ? io_req1_func : io_req0_func;

  // Illegal funcs still present the address but never enable the memory.
  always_comb begin
    io_mem_en      = 1'b0;
    io_mem_addr    = '0;
    io_mem_wr_data = '0;
    io_mem_func    = MEM_FUNC_RD;
    if (grant0 || grant1) begin
      io_mem_addr    = grant1 ? io_req1_addr  : io_req0_addr;
      io_mem_wr_data = grant1 ? io_req1_wdata : io_req0_wdata;
      if (func_legal(win_func)) begin
        io_mem_en   = 1'b1;
        io_mem_func = win_func;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_resp0_valid <= 1'b0;
      io_resp0_data  <= '0;
      io_resp0_err   <= 1'b0;
      io_resp1_valid <= 1'b0;
      io_resp1_data  <= '0;
      io_resp1_err   <= 1'b0;
    end else begin
      io_resp0_valid <= grant0;
      io_resp0_err   <= grant0 && !func_legal(io_req0_func);
      io_resp0_data  <= (grant0 && (io_req0_func == MEM_FUNC_RD)) ? io_mem_rd_data : '0;
      io_resp1_valid <= grant1;
      io_resp1_err   <= grant1 && !func_legal(io_req1_func);
      io_resp1_data  <= (grant1 && (io_req1_func == MEM_FUNC_RD)) ? io_mem_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour, hand sequences for lock and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
  logic [9:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [1:0]  f0 = '0, f1 = '0;
  logic        rdy0, rdy1, rv0, rv1, re0, re1, men;
  logic [31:0] rd0, rd1, mwd, mrd;
  logic [9:0]  maddr;
  logic [1:0]  mfunc;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .io_req0_valid(v0), .io_req0_ready(rdy0), .io_req0_addr(a0), .io_req0_wdata(d0),
    .io_req0_func(f0), .io_req0_lock(l0),
    .io_resp0_valid(rv0), .io_resp0_data(rd0), .io_resp0_err(re0),
    .io_req1_valid(v1), .io_req1_ready(rdy1), .io_req1_addr(a1), .io_req1_wdata(d1),
    .io_req1_func(f1), .io_req1_lock(l1),
    .io_resp1_valid(rv1), .io_resp1_data(rd1), .io_resp1_err(re1),
    .io_mem_addr(maddr), .io_mem_wr_data(mwd), .io_mem_func(mfunc), .io_mem_en(men),
    .io_mem_rd_data(mrd)
  );

  assign mrd = mem[maddr];
  always @(posedge clk) if (men && mfunc == 2'd1) mem[maddr] <= mwd;

  typedef struct {
    logic v0; logic [1:0] f0; logic [9:0] a0; logic [31:0] d0;
    logic v1; logic [1:0] f1; logic [9:0] a1; logic [31:0] d1;
    logic rdy0; logic rdy1; logic en; logic [9:0] maddr; logic [31:0] mwd; logic [1:0] mfunc;
    logic rv0; logic [31:0] rd0; logic re0;
    logic rv1; logic [31:0] rd1; logic re1;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic g_exp[7];
    int beat;

    vecs[0]  = '{1'b1, 2'd1, 10'h005, 32'hDEADBEEF, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 10'h005, 32'h0, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h005, 32'h0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 10'h000, 32'h0, 1'b1, 2'd1, 10'h020, 32'h11111111,
                 1'b0, 1'b1, 1'b1, 10'h020, 32'h11111111, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
    for (int i = 3; i < 9; i++) begin
      if (i % 2 == 1)
        vecs[i] = '{1'b1, 2'd0, 10'h005, 32'h0, 1'b1, 2'd0, 10'h020, 32'h0,
                    1'b1, 1'b0, 1'b1, 10'h005, 32'h0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0};
      else
        vecs[i] = '{1'b1, 2'd0, 10'h005, 32'h0, 1'b1, 2'd0, 10'h020, 32'h0,
                    1'b0, 1'b1, 1'b1, 10'h020, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111, 1'b0};
    end
    vecs[9]  = '{1'b1, 2'd1, 10'h010, 32'h12345678, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h010, 32'h12345678, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 10'h010, 32'hFFFFFFFF, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b0, 10'h010, 32'hFFFFFFFF, 2'd0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 2'd0, 10'h010, 32'h0, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h010, 32'h0, 2'd0, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[12] = '{1'b1, 2'd1, 10'h000, 32'h0BADF00D, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h000, 32'h0BADF00D, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 2'd1, 10'h3FF, 32'hA5A5A5A5, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h3FF, 32'hA5A5A5A5, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[14] = '{1'b1, 2'd0, 10'h000, 32'h0, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h000, 32'h0, 2'd0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[15] = '{1'b1, 2'd0, 10'h3FF, 32'h0, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b1, 1'b0, 1'b1, 10'h3FF, 32'h0, 2'd0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 2'd0, 10'h000, 32'h0, 1'b0, 2'd0, 10'h000, 32'h0,
                 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 10'h000, 32'h0, 1'b1, 2'd3, 10'h3FF, 32'h00000001,
                 1'b0, 1'b1, 1'b0, 10'h3FF, 32'h00000001, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[18] = '{1'b0, 2'd0, 10'h000, 32'h0, 1'b1, 2'd0, 10'h3FF, 32'h0,
                 1'b0, 1'b1, 1'b1, 10'h3FF, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0};

    #2;
    chk("reset_resp0_valid", 32'(rv0), 32'h0);
    chk("reset_resp1_valid", 32'(rv1), 32'h0);
    chk("reset_resp0_data", rd0, 32'h0);
    chk("reset_mem_en", 32'(men), 32'h0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      v0 = vecs[i].v0; f0 = vecs[i].f0; a0 = vecs[i].a0; d0 = vecs[i].d0;
      v1 = vecs[i].v1; f1 = vecs[i].f1; a1 = vecs[i].a1; d1 = vecs[i].d1;
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(rdy0), 32'(vecs[i].rdy0));
      chk($sformatf("v%0d_ready1", i), 32'(rdy1), 32'(vecs[i].rdy1));
      chk($sformatf("v%0d_mem_en", i), 32'(men), 32'(vecs[i].en));
      chk($sformatf("v%0d_mem_addr", i), 32'(maddr), 32'(vecs[i].maddr));
      chk($sformatf("v%0d_mem_wr_data", i), mwd, vecs[i].mwd);
      chk($sformatf("v%0d_mem_func", i), 32'(mfunc), 32'(vecs[i].mfunc));
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp0_valid", i), 32'(rv0), 32'(vecs[i].rv0));
      chk($sformatf("v%0d_resp0_data", i), rd0, vecs[i].rd0);
      chk($sformatf("v%0d_resp0_err", i), 32'(re0), 32'(vecs[i].re0));
      chk($sformatf("v%0d_resp1_valid", i), 32'(rv1), 32'(vecs[i].rv1));
      chk($sformatf("v%0d_resp1_data", i), rd1, vecs[i].rd1);
      chk($sformatf("v%0d_resp1_err", i), 32'(re1), 32'(vecs[i].re1));
    end
    v0 = 1'b0; v1 = 1'b0;

    // Port 1 six locked write beats against a continuously requesting port 0.
    g_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    beat = 0;
    f0 = 2'd0; a0 = 10'h005; d0 = 32'h0; l0 = 1'b0;
    f1 = 2'd1; l1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      v1 = 1'b1; a1 = 10'(10'h100 + beat); d1 = 32'hB0000000 + 32'(beat);
      v0 = (c > 0);
      #1;
      chk($sformatf("lock_c%0d_ready1", c), 32'(rdy1), 32'(g_exp[c]));
      chk($sformatf("lock_c%0d_ready0", c), 32'(rdy0), 32'((c > 0) && !g_exp[c]));
      @(posedge clk); #1;
      chk($sformatf("lock_c%0d_resp1_valid", c), 32'(rv1), 32'(g_exp[c]));
      chk($sformatf("lock_c%0d_resp0_valid", c), 32'(rv0), 32'((c > 0) && !g_exp[c]));
      if (g_exp[c]) beat++;
    end
    chk("lock_beats_done", 32'(beat), 32'd6);
    v0 = 1'b0; v1 = 1'b0; l1 = 1'b0;
    @(posedge clk); #1;

    // Reset between accept and response edge drops the response; round-robin returns to port 0.
    v0 = 1'b1; f0 = 2'd0; a0 = 10'h005;
    @(posedge clk); #1;
    chk("rst_pre_resp0_valid", 32'(rv0), 32'h1);
    v0 = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_resp0_valid", 32'(rv0), 32'h0);
    chk("rst_resp0_data", rd0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_rel_resp0_valid", 32'(rv0), 32'h0);
    chk("rst_rel_resp1_valid", 32'(rv1), 32'h0);
    chk("rst_rel_mem_en", 32'(men), 32'h0);
    chk("rst_rel_ready0", 32'(rdy0), 32'h0);
    v0 = 1'b1; f0 = 2'd0; a0 = 10'h005;
    v1 = 1'b1; f1 = 2'd0; a1 = 10'h020;
    #1;
    chk("rst_tie_ready0", 32'(rdy0), 32'h1);
    chk("rst_tie_ready1", 32'(rdy1), 32'h0);
    @(posedge clk); #1;
    chk("rst_tie_resp0_valid", 32'(rv0), 32'h1);
    chk("rst_tie_resp0_data", rd0, 32'hDEADBEEF);
    v0 = 1'b0; v1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory between the core load/store unit (port 0) and the host loader/debug port (port 1).
- Grants at most one request per cycle and drives the memory's addr/wr_data/mem_func/mem_en.
- Captures the memory's combinational read data into a registered response one cycle after grant.
- Round-robin fairness, with optional bounded bus lock for multi-beat transfers.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, data width.
- MAX_LOCK, 4, max consecutive grants one requester may hold while asserting lock (1..15).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_req0_valid  in  1  port 0 request valid.
- io_req0_ready  out  1  port 0 request accepted this cycle (combinational grant).
- io_req0_addr  in  ADDR_W  port 0 word address.
- io_req0_wdata  in  DATA_W  port 0 write data.
- io_req0_func  in  2  0=read, 1=write, 2/3=illegal.
- io_req0_lock  in  1  keep grant on the next cycle if still valid.
- io_resp0_valid  out  1  one-cycle response pulse.
- io_resp0_data  out  DATA_W  read data (0 for writes and errors).
- io_resp0_err  out  1  illegal func flag, qualified by resp0_valid.
- io_req1_* / io_resp1_*  same set as port 0 for port 1.
- io_mem_addr  out  ADDR_W  to memory address.
- io_mem_wr_data  out  DATA_W  to memory write data.
- io_mem_func  out  2  to memory func (0 read, 1 write).
- io_mem_en  out  1  to memory enable.
- io_mem_rd_data  in  DATA_W  combinational read data from memory.

Behaviour:
- Reset (async assert, sync release): all resp outputs 0, rr pointer = port 0 preferred, lock owner none, lock counter 0.
- Handshake: a request transfers when valid & ready in the same cycle. ready is a combinational function of the valids and arbiter state. At most one ready is high per cycle. A requester must hold addr/wdata/func/lock stable while valid & !ready.

Arbitration, per cycle:
- Lock active (owner set, owner valid, count < MAX_LOCK): grant owner.
- Otherwise, with exactly one valid: grant it.
- Otherwise, with both valid: grant the port the rr pointer favours. The pointer toggles to the other port after every grant.

Lock state:
- On a grant with lock=1: owner = granted port, count += 1.
- On a grant with lock=0, no grant, or count reaching MAX_LOCK: owner cleared, count = 0. The rr pointer then favours the non-owner.
- Owner dropping valid releases the lock the same cycle.

Memory drive and response:
- With a grant: mem_en=1, mem_addr/mem_wr_data mirror the winner's addr/wdata.
- mem_func = winner's func for func 0/1. For illegal func, mem_en=0 and mem_func=0.
- With no grant: mem_en=0; addr, wr_data and func driven 0.
- Response latency is exactly 1 cycle after the accept cycle. respN_valid=1 for one cycle.
- Read: data = mem_rd_data sampled at the accept edge.
- Write: data=0, err=0; the write has taken effect at the accept edge.
- Illegal func: data=0, err=1, no memory write.
- The non-granted port's resp_valid is 0.
- No response backpressure; the requester must consume in that cycle.

Boundaries:
- Back-to-back grants to the same port give resp on consecutive cycles.
- Read-after-write to the same address on the next cycle returns the new data.
- Address wrap: addr is passed through unmodified (ADDR_W bits).
- Reset asserted mid-transfer: the pending response is dropped (resp_valid forced 0 immediately); the memory write on the same edge is not guaranteed.

Decomposition:
- Shared package: MEM_FUNC_RD=2'h0, MEM_FUNC_WR=2'h1, ADDR_W, DATA_W constants; mirrors the memory's func encoding.
- One sub-module: dmem_rr_arb (2-way round-robin with lock owner/counter). It outputs grant0/grant1. The top holds the muxing and response registers.

Test Plan:
- Port 0 only: write addr 0x005 data 0xDEADBEEF, then read 0x005 -> ready same cycle; resp0_valid next cycle each; read data 0xDEADBEEF, err=0.
- Both valid every cycle, no lock, 6 cycles -> grants alternate 0,1,0,1,0,1; resp valids alternate one cycle later.
- Port 1 lock=1 with 6 beats, port 0 valid throughout, MAX_LOCK=4 -> port 1 granted 4 consecutive cycles, then port 0 once, then port 1 resumes.
- Port 0 func=2 at addr 0x010 (pre-written 0x12345678) -> mem_en=0; resp0 valid with err=1, data=0; subsequent read of 0x010 returns 0x12345678.
- Address 0x3FF write 0xA5A5A5A5, then 0x000 read -> correct independent data; no wrap corruption.
- Port 0 read accepted, reset asserted before next edge -> resp0_valid=0 immediately; after release all outputs 0, and port 0 wins the first simultaneous request.
